restoring_div_ctrl: RTL



---
 rtl/div_pkg.sv | 13 +
 rtl/restoring_div_step.sv | 35 +++
 rtl/restoring_div_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the restoring divider and its display wiring.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Operand width used by the top level and the seven-segment display path.
   localparam int DIV_WIDTH = 16;

endpackage : div_pkg

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift the partial remainder left by one
// dividend bit, trial-subtract the divisor, and restore if the result went
// negative. The new quotient bit enters the bottom of Q.
module restoring_div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   a_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH:0]   a_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] a_shift;
   logic [WIDTH:0] trial;

   // The partial remainder is always below the divisor after a step, so the
   // MSB of A is zero on entry and is simply shifted out.
   logic a_msb_unused;
   assign a_msb_unused = a_i[WIDTH];

   // Shift, trial subtract, then keep or restore.
   always_comb begin
      a_shift = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
      trial   = a_shift - {1'b0, m_i};
      if (trial[WIDTH]) begin
         a_o = a_shift;
         q_o = {q_i[WIDTH-2:0], 1'b0};
      end else begin
         a_o = trial;
         q_o = {q_i[WIDTH-2:0], 1'b1};
      end
   end

endmodule : restoring_div_step

// File: rtl/restoring_div_ctrl.sv
// Iterative unsigned restoring divider with its own IDLE/RUN/DONE sequencer.
// One step per clock in RUN; results are held for the display until the next
// completion, and done pulses for the single cycle spent in DONE.
module restoring_div_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int             CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_t       state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   a_step;
   logic [WIDTH-1:0] q_step;

   restoring_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .a_i (a_q),
      .q_i (q_q),
      .m_i (m_q),
      .a_o (a_step),
      .q_o (q_step)
   );

   // Sequencer: operand capture, iteration, and result write-back.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      q_d         = q_q;
      m_d         = m_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d   = '0;
               q_d   = dividend;
               m_d   = divisor;
               cnt_d = '0;
               if (divisor == '0) begin
                  // No iterations: report all-ones quotient and pass the
                  // dividend through as the remainder.
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
                  state_d     = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            a_d = a_step;
            q_d = q_step;
            if (cnt_q == CNT_LAST) begin
               quotient_d  = q_step;
               remainder_d = a_step[WIDTH-1:0];
               dbz_d       = 1'b0;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any division in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         q_q         <= '0;
         m_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         q_q         <= q_d;
         m_q         <= m_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule : restoring_div_ctrl
